// File: rtl/axi_write_master.sv
// Write-burst generator: takes one command, drives AW, then len+1 generated W beats, then
// collects the B response and reports it with a one-cycle done pulse.
module axi_write_master #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic          axi_aclk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [2:0]    cmd_size,
  input  logic [1:0]    cmd_burst,
  input  logic [DW-1:0] cmd_seed,
  output logic [AW-1:0] awaddr_out,
  output logic [7:0]    awlen_out,
  output logic [2:0]    awsize_out,
  output logic [1:0]    awburst_out,
  output logic          awvalid_out,
  input  logic          awready,
  output logic [DW-1:0] wdata_out,
  output logic [7:0]    wstrb_out,
  output logic          wlast_out,
  output logic          wvalid_out,
  input  logic          wready,
  input  logic [1:0]    bresp,
  input  logic          bvalid,
  output logic          bready_out,
  output logic          done,
  output logic [1:0]    resp_out,
  output logic          busy
);

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] BurstWrap = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   baddr_q, baddr_d;
  logic [7:0]      len_q, len_d;
  logic [2:0]      size_q, size_d;
  logic [1:0]      burst_q, burst_d;
  logic [DW-1:0]   seed_q, seed_d;
  logic [7:0]      beat_q, beat_d;
  logic            done_q, done_d;
  logic [1:0]      resp_q, resp_d;

  logic [3:0]      nbytes;
  logic [AW-1:0]   lane_mask, aligned, incr_addr, wrap_mask, next_addr;
  logic [15:0]     lanes;
  logic [7:0]      strb;
  logic            wrap_len_ok, cmd_bad;

  // Address and strobe of the beat currently presented on W.
  always_comb begin
    nbytes    = 4'd1 << size_q;
    lane_mask = AW'(nbytes) - AW'(1);
    aligned   = baddr_q & ~lane_mask;
    incr_addr = aligned + AW'(nbytes);
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    unique case (burst_q)
      BurstIncr: next_addr = incr_addr;
      BurstWrap: next_addr = (baddr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default:   next_addr = baddr_q;
    endcase
    lanes = ((16'd1 << nbytes) - 16'd1) << (baddr_q[2:0] & ~lane_mask[2:0]);
    strb  = lanes[7:0];
    // Unaligned first beat of INCR/FIXED: drop the bytes below the start address.
    if (beat_q == 8'd0 && burst_q != BurstWrap) begin
      strb = strb & (8'hFF << baddr_q[2:0]);
    end
  end

  always_comb begin
    wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) ||
                  (cmd_len == 8'd15);
    cmd_bad     = (cmd_size > 3'd3) || (cmd_burst == 2'b11) ||
                  ((cmd_burst == BurstWrap) && !wrap_len_ok);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    baddr_d = baddr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    seed_d  = seed_q;
    beat_d  = beat_q;
    resp_d  = resp_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          baddr_d = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          seed_d  = cmd_seed;
          beat_d  = 8'd0;
          if (cmd_bad) begin
            done_d = 1'b1;
            resp_d = 2'b11;
          end else begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        if (awready) state_d = StData;
      end
      StData: begin
        if (wready) begin
          if (beat_q == len_q) begin
            state_d = StResp;
          end else begin
            beat_d  = beat_q + 8'd1;
            baddr_d = next_addr;
          end
        end
      end
      StResp: begin
        if (bvalid) begin
          resp_d  = bresp;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      baddr_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      done_q  <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      baddr_q <= baddr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      seed_q  <= seed_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign awvalid_out = (state_q == StAddr);
  assign wvalid_out  = (state_q == StData);
  assign bready_out  = (state_q == StResp);
  assign awaddr_out  = addr_q;
  assign awlen_out   = len_q;
  assign awsize_out  = size_q;
  assign awburst_out = burst_q;
  assign wdata_out   = wvalid_out ? (seed_q + DW'(beat_q)) : '0;
  assign wstrb_out   = wvalid_out ? strb : 8'h00;
  assign wlast_out   = wvalid_out && (beat_q == len_q);
  assign done        = done_q;
  assign resp_out    = resp_q;

endmodule

// File: tb/tb_axi_write_master.sv
// Randomized bench for axi_write_master: a transaction-level model predicts every output on
// every cycle; a few literal expectations pin the model for the directed cases.
module tb_axi_write_master;

  logic        axi_aclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [63:0] cmd_seed;
  logic [31:0] awaddr_out;
  logic [7:0]  awlen_out;
  logic [2:0]  awsize_out;
  logic [1:0]  awburst_out;
  logic        awvalid_out, awready;
  logic [63:0] wdata_out;
  logic [7:0]  wstrb_out;
  logic        wlast_out, wvalid_out, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready_out, done, busy;
  logic [1:0]  resp_out;

  axi_write_master #(.AW(32), .DW(64)) dut (
    .axi_aclk(axi_aclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_seed(cmd_seed),
    .awaddr_out(awaddr_out), .awlen_out(awlen_out), .awsize_out(awsize_out),
    .awburst_out(awburst_out), .awvalid_out(awvalid_out), .awready(awready),
    .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wlast_out(wlast_out),
    .wvalid_out(wvalid_out), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready_out(bready_out),
    .done(done), .resp_out(resp_out), .busy(busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks = 0;
  int errors = 0;

  // Transaction model: which phase is outstanding and the precomputed beat list.
  bit          m_aw, m_w, m_b, m_done;
  logic [1:0]  m_resp;
  int          m_idx, m_len;
  logic [31:0] m_addr0;
  logic [7:0]  m_awlen;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic [31:0] b_addr[256];
  logic [63:0] b_data[256];
  logic [7:0]  b_strb[256];

  // Stimulus controls.
  bit          pend;
  logic [31:0] p_addr;
  logic [7:0]  p_len;
  logic [2:0]  p_size;
  logic [1:0]  p_burst;
  logic [63:0] p_seed;
  int          aw_hold, aw_cycles;
  bit          aw_rand, w_rand, w_tog_mode, w_tog, b_rand, bresp_fixed;
  logic [1:0]  bresp_val;
  logic [63:0] log_data[$];
  logic [7:0]  log_strb[$];

  function automatic bit m_idle();
    return !m_aw && !m_w && !m_b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("cmd_ready", cmd_ready, m_idle());
    chk("busy", busy, !m_idle());
    chk("done", done, m_done);
    chk("resp_out", resp_out, m_resp);
    chk("awvalid", awvalid_out, m_aw);
    chk("wvalid", wvalid_out, m_w);
    chk("bready", bready_out, m_b);
    if (m_aw) begin
      chk("awaddr", awaddr_out, m_addr0);
      chk("awlen", awlen_out, m_awlen);
      chk("awsize", awsize_out, m_size);
      chk("awburst", awburst_out, m_burst);
    end
    if (m_w) begin
      chk("wdata", wdata_out, b_data[m_idx]);
      chk("wstrb", wstrb_out, b_strb[m_idx]);
      chk("wlast", wlast_out, m_idx == m_len);
    end else begin
      chk("wlast_idle", wlast_out, 1'b0);
    end
  endtask

  // Beat list from the burst rules, in closed form per beat index.
  task automatic model_accept();
    bit          bad;
    int unsigned nb, wsz, lo;
    logic [31:0] al, base, a;
    logic [7:0]  s;
    bad = (cmd_size > 3) || (cmd_burst == 2'b11) ||
          (cmd_burst == 2'b10 && !(cmd_len == 1 || cmd_len == 3 || cmd_len == 7 ||
                                   cmd_len == 15));
    if (bad) begin
      m_done = 1'b1;
      m_resp = 2'b11;
      return;
    end
    m_aw    = 1'b1;
    m_addr0 = cmd_addr;
    m_awlen = cmd_len;
    m_size  = cmd_size;
    m_burst = cmd_burst;
    m_len   = int'(cmd_len);
    nb      = 1 << cmd_size;
    wsz     = (m_len + 1) * nb;
    al      = cmd_addr - (cmd_addr % nb);
    base    = cmd_addr - (cmd_addr % wsz);
    for (int i = 0; i <= m_len; i++) begin
      if (i == 0 || cmd_burst == 2'b00) a = cmd_addr;
      else if (cmd_burst == 2'b01) a = al + i * nb;
      else a = base + ((al - base + i * nb) % wsz);
      b_addr[i] = a;
      b_data[i] = cmd_seed + 64'(i);
      lo = ((a % 8) / nb) * nb;
      s = 8'h00;
      for (int l = 0; l < 8; l++) begin
        if (l >= lo && l < lo + nb && !(i == 0 && cmd_burst != 2'b10 && l < cmd_addr % 8))
          s[l] = 1'b1;
      end
      b_strb[i] = s;
    end
  endtask

  task automatic step();
    @(negedge axi_aclk);
    check_outputs();
    if (awvalid_out) aw_cycles++;
    cmd_valid = 1'b0;
    if (m_idle()) begin
      if (pend) begin
        cmd_valid = 1'b1;
        cmd_addr  = p_addr;
        cmd_len   = p_len;
        cmd_size  = p_size;
        cmd_burst = p_burst;
        cmd_seed  = p_seed;
        pend      = 1'b0;
      end
    end else if ($urandom_range(3) == 0) begin
      cmd_valid = 1'b1;
      cmd_addr  = $urandom;
      cmd_len   = 8'($urandom);
      cmd_size  = 3'($urandom);
      cmd_burst = 2'($urandom);
      cmd_seed  = {$urandom, $urandom};
    end
    if (aw_hold > 0 && m_aw) begin
      awready = 1'b0;
      aw_hold--;
    end else begin
      awready = aw_rand ? 1'($urandom) : 1'b1;
    end
    if (w_tog_mode) begin
      w_tog  = !w_tog;
      wready = w_tog;
    end else begin
      wready = w_rand ? 1'($urandom) : 1'b1;
    end
    bvalid = b_rand ? 1'($urandom) : 1'b1;
    bresp  = bresp_fixed ? bresp_val : 2'($urandom);
    if (wvalid_out && wready) begin
      log_data.push_back(wdata_out);
      log_strb.push_back(wstrb_out);
    end
    // Advance the model to what the DUT must show after the coming edge.
    m_done = 1'b0;
    if (m_idle()) begin
      if (cmd_valid) model_accept();
    end else if (m_aw) begin
      if (awready) begin
        m_aw  = 1'b0;
        m_w   = 1'b1;
        m_idx = 0;
      end
    end else if (m_w) begin
      if (wready) begin
        if (m_idx == m_len) begin
          m_w = 1'b0;
          m_b = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end else if (bvalid) begin
      m_b    = 1'b0;
      m_done = 1'b1;
      m_resp = bresp;
    end
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_idle() && !pend) && n < max);
    if (!(m_idle() && !pend)) begin
      checks++;
      errors++;
      $display("FAIL timeout: burst still open after %0d cycles, required idle", n);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                      input logic [1:0] bu, input logic [63:0] sd);
    p_addr  = a;
    p_len   = l;
    p_size  = sz;
    p_burst = bu;
    p_seed  = sd;
    pend    = 1'b1;
    wait_idle(1000);
  endtask

  initial begin
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [7:0]  r_len;
    logic [31:0] r_addr;
    int          n;
    cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0; cmd_seed = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    m_aw = 0; m_w = 0; m_b = 0; m_done = 0; m_resp = 0; m_idx = 0; m_len = 0;
    pend = 0; aw_hold = 0; aw_cycles = 0;
    aw_rand = 0; w_rand = 0; w_tog_mode = 0; w_tog = 0; b_rand = 0;
    bresp_fixed = 1; bresp_val = 2'b00;

    repeat (3) @(negedge axi_aclk);
    check_outputs();
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset wdata", wdata_out, 64'h0);
    rst_n = 1'b1;

    // 1: single-beat INCR, everything ready.
    log_data.delete(); log_strb.delete();
    send(32'h100, 8'd0, 3'd3, 2'b01, 64'hA5);
    step();
    chk("t1 done", done, 1'b1);
    chk("t1 beats", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("t1 data", log_data[0], 64'hA5);
      chk("t1 strb", log_strb[0], 8'hFF);
    end

    // 2: narrow INCR with wready toggling.
    w_tog_mode = 1; w_tog = 0;
    log_data.delete(); log_strb.delete();
    send(32'h104, 8'd3, 3'd2, 2'b01, 64'h10);
    step();
    w_tog_mode = 0;
    chk("t2 beats", log_data.size(), 4);
    if (log_data.size() == 4) begin
      chk("t2 data0", log_data[0], 64'h10); chk("t2 strb0", log_strb[0], 8'hF0);
      chk("t2 data1", log_data[1], 64'h11); chk("t2 strb1", log_strb[1], 8'h0F);
      chk("t2 data2", log_data[2], 64'h12); chk("t2 strb2", log_strb[2], 8'hF0);
      chk("t2 data3", log_data[3], 64'h13); chk("t2 strb3", log_strb[3], 8'h0F);
    end

    // 3: WRAP addresses.
    log_data.delete(); log_strb.delete();
    send(32'h18, 8'd3, 3'd3, 2'b10, 64'h1000);
    step();
    chk("t3 addr0", b_addr[0], 32'h18); chk("t3 addr1", b_addr[1], 32'h00);
    chk("t3 addr2", b_addr[2], 32'h08); chk("t3 addr3", b_addr[3], 32'h10);
    chk("t3 beats", log_strb.size(), 4);
    foreach (log_strb[i]) chk("t3 strb", log_strb[i], 8'hFF);

    // 4: awready low for 5 cycles.
    aw_hold = 5; aw_cycles = 0;
    send(32'h2000, 8'd1, 3'd3, 2'b01, 64'h55);
    step();
    chk("t4 aw cycles", aw_cycles, 6);

    // 5: illegal size rejected.
    aw_cycles = 0;
    send(32'h300, 8'd0, 3'd4, 2'b01, 64'h0);
    step();
    chk("t5 done", done, 1'b1);
    chk("t5 resp", resp_out, 2'b11);
    chk("t5 no aw", aw_cycles, 0);
    step();
    chk("t5 cmd_ready", cmd_ready, 1'b1);

    // 6: reset while beat 2 is on the bus, then a normal burst with SLVERR.
    p_addr = 32'h4000; p_len = 8'd7; p_size = 3'd3; p_burst = 2'b01; p_seed = 64'h900;
    pend = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_w && m_idx == 2) && n < 50);
    chk("t6 reached beat2", m_w && m_idx == 2, 1'b1);
    @(posedge axi_aclk);
    #2;
    chk("t6 pre wvalid", wvalid_out, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6 rst wvalid", wvalid_out, 1'b0);
    chk("t6 rst awvalid", awvalid_out, 1'b0);
    chk("t6 rst bready", bready_out, 1'b0);
    chk("t6 rst done", done, 1'b0);
    chk("t6 rst cmd_ready", cmd_ready, 1'b1);
    m_aw = 0; m_w = 0; m_b = 0; m_done = 0; m_resp = 2'b00; pend = 0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge axi_aclk);
    check_outputs();
    rst_n = 1'b1;
    bresp_val = 2'b10;
    send(32'h5000, 8'd1, 3'd3, 2'b01, 64'h77);
    step();
    chk("t6 resp", resp_out, 2'b10);

    // Random traffic with random handshakes and response codes.
    aw_rand = 1; w_rand = 1; b_rand = 1; bresp_fixed = 0;
    for (int k = 0; k < 40; k++) begin
      r_size  = 3'($urandom_range(0, 3));
      r_burst = 2'($urandom_range(0, 2));
      r_len   = 8'($urandom_range(0, 15));
      if (r_burst == 2'b10) begin
        case ($urandom_range(0, 3))
          0: r_len = 8'd1;
          1: r_len = 8'd3;
          2: r_len = 8'd7;
          default: r_len = 8'd15;
        endcase
      end
      r_addr = $urandom;
      if (r_burst == 2'b10) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      case ($urandom_range(0, 11))
        0: r_size = 3'($urandom_range(4, 7));
        1: r_burst = 2'b11;
        2: begin r_burst = 2'b10; r_len = 8'd2; end
        default: ;
      endcase
      send(r_addr, r_len, r_size, r_burst, {$urandom, $urandom});
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- Upstream write-traffic generator that feeds the AXI protocol FSM's write inputs (awvalid_in/aw*_in, wvalid_in/wdata_in/wstrb_in, bready_in).
- Accepts one burst command at a time. Issues the AW beat, then len+1 W beats with generated data and byte strobes, then waits for the B response.
- Reports completion and the response code to the test/control logic.
- One burst outstanding; AW, W and B phases are strictly sequential.

Parameters:
- AW, 32, address width.
- DW, 64, data width (fixed at 64; strobe width DW/8 = 8).

Ports:
- axi_aclk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  burst command valid.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  input  AW  start address.
- cmd_len  input  8  beats minus one.
- cmd_size  input  3  log2 bytes per beat.
- cmd_burst  input  2  00 FIXED, 01 INCR, 10 WRAP.
- cmd_seed  input  DW  data of beat 0.
- awaddr_out  output  AW  write address.
- awlen_out  output  8  burst length.
- awsize_out  output  3  burst size.
- awburst_out  output  2  burst type.
- awvalid_out  output  1  address valid.
- awready  input  1  address ready.
- wdata_out  output  DW  write data.
- wstrb_out  output  8  byte strobes.
- wlast_out  output  1  last beat.
- wvalid_out  output  1  data valid.
- wready  input  1  data ready.
- bresp  input  2  write response code.
- bvalid  input  1  response valid.
- bready_out  output  1  response ready.
- done  output  1  one-cycle pulse, burst finished or rejected.
- resp_out  output  2  captured bresp; 2'b11 on rejected command.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, except cmd_ready = 1.
  - State IDLE, beat counter 0.
  - Reset mid-burst drops all valids immediately with no completion pulse.
- States: IDLE, ADDR, DATA, RESP.
- cmd_ready = (state == IDLE), driven combinationally from state.
- IDLE, on command handshake at cycle N:
  - Latch the command.
  - If cmd_size > 3 or cmd_burst == 11: reject. done = 1 and resp_out = 11 at N+1; stay IDLE; no bus activity.
  - If cmd_burst == WRAP and cmd_len is not 1, 3, 7 or 15: reject the same way.
  - Otherwise awvalid_out = 1 at N+1 with the latched fields; go to ADDR.
- ADDR:
  - awvalid_out and all aw*_out fields held stable until awready.
  - On awvalid_out && awready at cycle M: awvalid_out = 0 and wvalid_out = 1 at M+1 with beat 0; go to DATA.
- DATA:
  - wvalid_out and wdata/wstrb/wlast held stable until wready.
  - On each handshake: beat counter +1 and the next beat is presented the following cycle, so wvalid_out stays 1 back-to-back.
  - wlast_out = 1 only when beat counter == latched len; len = 0 gives wlast on beat 0.
  - After the wlast handshake at cycle L: wvalid_out = 0 and wlast_out = 0 at L+1, bready_out = 1; go to RESP.
- Data rule: wdata_out = seed + beat_index, modulo 2^64.
- Beat address:
  - Beat 0 address is cmd_addr.
  - FIXED: constant.
  - INCR: previous address aligned down to 2^size, plus 2^size.
  - WRAP: aligned increment within the boundary of (len+1)*2^size bytes. Low bits wrap, upper bits preserved.
- Strobe rule: wstrb_out = ((1 << 2^size) - 1) << (beat_addr[2:0] & ~(2^size - 1)), truncated to 8 bits. For beat 0 only, INCR/FIXED, bytes below the unaligned start address are also cleared.
- RESP:
  - On bvalid && bready_out at cycle R: resp_out = bresp, done = 1, bready_out = 0 at R+1; go to IDLE.
  - resp_out holds until the next completion.
- Signals are never deasserted while waiting for ready; a valid never depends on its ready.
- bvalid arriving before RESP is ignored; bready_out is low outside RESP.

Test Plan:
1. Reset then a single-beat INCR command (addr 0x100, len 0, size 3, seed 0xA5) with awready/wready/bvalid tied high:
   - awvalid 1 cycle after cmd handshake.
   - One W beat: data 0xA5, strb 0xFF, wlast 1.
   - done pulse with resp_out 00.
2. INCR, len 3, size 2, addr 0x104, seed 0x10, with wready toggling 1/0 each cycle:
   - Data sequence 0x10, 0x11, 0x12, 0x13.
   - Strobes 0xF0, 0x0F, 0xF0, 0x0F.
   - wlast only on beat 3; fields stable during stalls.
3. WRAP, len 3, size 3, addr 0x18: beat addresses 0x18, 0x00, 0x08, 0x10; all strobes 0xFF.
4. awready held low 5 cycles: awvalid_out and awaddr_out stable throughout; no wvalid_out before the AW handshake.
5. Reject cmd_size 4: done pulse, resp_out 11, awvalid_out never asserted; cmd_ready high again next cycle.
6. rst_n low during DATA beat 2: all valids 0 immediately (asynchronously); no done pulse; next command runs normally. Also check bresp 10 captured into resp_out.
